router_pkt_tx: RTL and testbench

Packet source for the router 1x3 input port. It takes a packet request (destination address, payload length) and a local payload byte stream, and serialises one packet onto the router input bus: header byte, then payload bytes, then the parity byte. It honours the router's busy back-pressure and can deliberately corrupt parity for error-path testing. It sits upstream of the router input register/FSM.

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_pkt_tx.sv | 154 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: default length width,
// the reserved destination code, the transmit state encoding and header packing.
package router_pkg;

    localparam int LEN_W_DEF = 6;

    // Destination code 3 has no router output port behind it.
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } tx_state_e;

    // Header byte carries the payload length in the upper bits, destination in the low two.
    function automatic logic [7:0] build_header(input logic [LEN_W_DEF-1:0] len,
                                                input logic [1:0]           addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_tx.sv
// Serialises one packet (header, payload bytes, parity) onto the router 1x3
// input bus, honouring busy back-pressure. Parity may be deliberately inverted.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int LEN_W      = LEN_W_DEF,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       dest_addr,
    input  logic [LEN_W-1:0] payload_len,
    input  logic             corrupt_parity,
    output logic             req_ready,
    input  logic [7:0]       pl_data,
    input  logic             pl_valid,
    output logic             pl_ready,
    input  logic             busy,
    output logic [7:0]       data_out,
    output logic             pkt_valid,
    output logic             tx_active,
    output logic             done,
    output logic             err_cfg,
    output logic             underrun
);

    localparam int GAP_W = 8;

    tx_state_e        state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       parity_q, parity_d;
    logic             corrupt_q, corrupt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             underrun_q, underrun_d;

    logic [7:0]       hdr_byte;
    logic [7:0]       pay_byte;

    assign hdr_byte = build_header(payload_len, dest_addr);
    // A missing source byte is replaced by zero so the packet length stays intact.
    assign pay_byte = pl_valid ? pl_data : 8'h00;

    // State register and registered bus outputs; reset aborts any packet in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            data_q      <= 8'h00;
            pkt_valid_q <= 1'b0;
            count_q     <= '0;
            len_q       <= '0;
            parity_q    <= 8'h00;
            corrupt_q   <= 1'b0;
            gap_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            pkt_valid_q <= pkt_valid_d;
            count_q     <= count_d;
            len_q       <= len_d;
            parity_q    <= parity_d;
            corrupt_q   <= corrupt_d;
            gap_q       <= gap_d;
            done_q      <= done_d;
            err_q       <= err_d;
            underrun_q  <= underrun_d;
        end
    end

    // Next-state logic: everything holds by default, pulses default low.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        pkt_valid_d = pkt_valid_q;
        count_d     = count_q;
        len_d       = len_q;
        parity_d    = parity_q;
        corrupt_d   = corrupt_q;
        gap_d       = gap_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        underrun_d  = 1'b0;
        pl_ready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (payload_len == '0 || dest_addr == ADDR_INVALID) begin
                        err_d = 1'b1;
                    end else begin
                        len_d       = payload_len;
                        corrupt_d   = corrupt_parity;
                        data_d      = hdr_byte;
                        pkt_valid_d = 1'b1;
                        parity_d    = hdr_byte;
                        count_d     = '0;
                        state_d     = ST_HEADER;
                    end
                end
            end
            ST_HEADER, ST_PAYLOAD: begin
                if (!busy) begin
                    if (count_q < len_q) begin
                        pl_ready   = 1'b1;
                        data_d     = pay_byte;
                        parity_d   = parity_q ^ pay_byte;
                        count_d    = count_q + 1'b1;
                        underrun_d = ~pl_valid;
                        state_d    = ST_PAYLOAD;
                    end else begin
                        data_d      = corrupt_q ? ~parity_q : parity_q;
                        pkt_valid_d = 1'b0;
                        state_d     = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (!busy) begin
                    data_d  = 8'h00;
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign tx_active = (state_q != ST_IDLE);
    assign data_out  = data_q;
    assign pkt_valid = pkt_valid_q;
    assign done      = done_q;
    assign err_cfg   = err_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: packet-level reference model compared
// every cycle, plus literal byte-stream expectations for the directed packets.
module tb_router_pkt_tx;

    localparam int G = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] dest_addr = 2'd0;
    logic [5:0] payload_len = 6'd0;
    logic       corrupt_parity = 1'b0;
    logic       req_ready;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy = 1'b0;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_active;
    logic       done;
    logic       err_cfg;
    logic       underrun;

    router_pkt_tx #(.LEN_W(6), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .start(start), .dest_addr(dest_addr),
        .payload_len(payload_len), .corrupt_parity(corrupt_parity),
        .req_ready(req_ready), .pl_data(pl_data), .pl_valid(pl_valid),
        .pl_ready(pl_ready), .busy(busy), .data_out(data_out),
        .pkt_valid(pkt_valid), .tx_active(tx_active), .done(done),
        .err_cfg(err_cfg), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Payload source: slot k of the packet is fed from pay_mem[k]; drop_mem marks empty slots.
    logic [7:0] pay_mem [0:63];
    logic       drop_mem [0:63];
    logic [5:0] fidx = 6'd0;
    logic       feed_clr = 1'b0;
    assign pl_data  = pay_mem[fidx];
    assign pl_valid = ~drop_mem[fidx];

    always @(posedge clk) begin
        if (feed_clr)      fidx <= 6'd0;
        else if (pl_ready) fidx <= fidx + 6'd1;
    end

    // Log of bytes the router actually took ({pkt_valid, data}).
    logic [8:0] log_q[$];
    int         log_lim = 0;
    always @(posedge clk) begin
        if (!reset && tx_active && !busy && log_q.size() < log_lim)
            log_q.push_back({pkt_valid, data_out});
    end

    // Packet-level reference model. phase: 0 idle, 1 header/payload on bus,
    // 2 parity on bus, 3 inter-packet gap. m_sent = payload bytes already taken.
    int         m_phase = 0;
    int         m_len = 0, m_sent = 0, m_gap = 0;
    logic       m_corr = 1'b0;
    logic [7:0] m_par = 8'h00;
    logic [7:0] e_data = 8'h00;
    logic       e_valid = 1'b0, e_done = 1'b0, e_err = 1'b0, e_under = 1'b0;
    logic [7:0] b;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; e_data = 8'h00; e_valid = 1'b0;
            e_done = 1'b0; e_err = 1'b0; e_under = 1'b0;
        end else begin
            e_done = 1'b0; e_err = 1'b0; e_under = 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    if (dest_addr == 2'd3 || payload_len == 6'd0) begin
                        e_err = 1'b1;
                    end else begin
                        m_len   = int'(payload_len);
                        m_corr  = corrupt_parity;
                        m_par   = 8'(int'(payload_len) * 4 + int'(dest_addr));
                        m_sent  = 0;
                        e_data  = m_par;
                        e_valid = 1'b1;
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (!busy) begin
                    if (m_sent < m_len) begin
                        b = pl_valid ? pl_data : 8'h00;
                        e_under = !pl_valid;
                        m_par  = m_par ^ b;
                        e_data = b;
                        m_sent++;
                    end else begin
                        e_data  = m_corr ? ~m_par : m_par;
                        e_valid = 1'b0;
                        m_phase = 2;
                    end
                end
            end else if (m_phase == 2) begin
                if (!busy) begin
                    e_data = 8'h00;
                    e_done = 1'b1;
                    m_gap  = G;
                    m_phase = (G > 0) ? 3 : 0;
                end
            end else begin
                m_gap--;
                if (m_gap == 0) m_phase = 0;
            end
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        chk("data_out",  32'(data_out),  32'(e_data));
        chk("pkt_valid", 32'(pkt_valid), 32'(e_valid));
        chk("done",      32'(done),      32'(e_done));
        chk("err_cfg",   32'(err_cfg),   32'(e_err));
        chk("underrun",  32'(underrun),  32'(e_under));
        chk("req_ready", 32'(req_ready), 32'(m_phase == 0));
        chk("tx_active", 32'(tx_active), 32'(m_phase != 0));
        chk("pl_ready",  32'(pl_ready),  32'(m_phase == 1 && !busy && m_sent < m_len));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] a, input int l, input logic c,
                        input int busy_n, input int drop_i);
        bit seen;
        for (int i = 0; i < 64; i++) drop_mem[i] = 1'b0;
        if (drop_i >= 0) drop_mem[drop_i] = 1'b1;
        log_q.delete();
        log_lim = l + 2;
        feed_clr = 1'b1;
        dest_addr = a; payload_len = 6'(l); corrupt_parity = c; start = 1'b1;
        cyc();
        feed_clr = 1'b0; start = 1'b0;
        if (busy_n > 0) begin
            busy = 1'b1;
            repeat (busy_n) cyc();
            chk("hdr_held_busy", 32'(data_out), 32'(8'(l * 4 + int'(a))));
            busy = 1'b0;
        end
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            cyc();
            if (done) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            if (req_ready) seen = 1; else cyc();
        end
        chk("back_idle", 32'(seen), 32'd1);
    endtask

    task automatic chk_log(input string name, input logic [8:0] exp[$]);
        chk({name, "_len"}, 32'(log_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            chk($sformatf("%s_b%0d", name, i), 32'(log_q[i]), 32'(exp[i]));
        $display("[TB] packet %s: %0d bytes logged", name, log_q.size());
    endtask

    initial begin
        logic [8:0] exp_q[$];
        bit seen;
        for (int i = 0; i < 64; i++) begin pay_mem[i] = 8'h00; drop_mem[i] = 1'b0; end
        repeat (3) cyc();
        reset = 1'b0;
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(pkt_valid), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h1);
        cyc();

        // addr 2, len 8, payload 01..08
        for (int i = 0; i < 8; i++) pay_mem[i] = 8'(i + 1);
        send(2'd2, 8, 1'b0, 0, -1);
        exp_q = '{9'h122, 9'h101, 9'h102, 9'h103, 9'h104, 9'h105, 9'h106, 9'h107, 9'h108, 9'h02A};
        chk_log("a2l8", exp_q);

        // same packet, inverted parity
        send(2'd2, 8, 1'b1, 0, -1);
        exp_q = '{9'h122, 9'h101, 9'h102, 9'h103, 9'h104, 9'h105, 9'h106, 9'h107, 9'h108, 9'h0D5};
        chk_log("a2l8_corrupt", exp_q);

        // addr 0, len 1, busy on the header for 3 cycles
        pay_mem[0] = 8'hFF;
        send(2'd0, 1, 1'b0, 3, -1);
        exp_q = '{9'h104, 9'h1FF, 9'h0FB};
        chk_log("a0l1_busy", exp_q);

        // illegal requests: addr 3, then len 0
        dest_addr = 2'd3; payload_len = 6'd5; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("err_addr3", 32'(err_cfg), 32'h1);
        chk("err_addr3_ready", 32'(req_ready), 32'h1);
        cyc();
        chk("err_addr3_pulse", 32'(err_cfg), 32'h0);
        dest_addr = 2'd1; payload_len = 6'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("err_len0", 32'(err_cfg), 32'h1);
        chk("err_len0_valid", 32'(pkt_valid), 32'h0);
        cyc();
        $display("[TB] illegal requests issued");

        // len 4, addr 1, third payload slot has no source byte
        pay_mem[0] = 8'h11; pay_mem[1] = 8'h22; pay_mem[2] = 8'h33; pay_mem[3] = 8'h44;
        send(2'd1, 4, 1'b0, 0, 2);
        exp_q = '{9'h111, 9'h111, 9'h122, 9'h100, 9'h144, 9'h066};
        chk_log("a1l4_underrun", exp_q);

        // reset after second payload byte aborts the packet
        for (int i = 0; i < 8; i++) begin pay_mem[i] = 8'(8'hA0 + i); drop_mem[i] = 1'b0; end
        feed_clr = 1'b1;
        dest_addr = 2'd1; payload_len = 6'd5; corrupt_parity = 1'b0; start = 1'b1;
        cyc();
        feed_clr = 1'b0; start = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (fidx == 6'd2) seen = 1; else cyc();
        end
        chk("abort_reach", 32'(seen), 32'h1);
        chk("abort_byte2", 32'(data_out), 32'hA1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("abort_data", 32'(data_out), 32'h0);
        chk("abort_valid", 32'(pkt_valid), 32'h0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (done) seen = 1;
        end
        chk("abort_no_done", 32'(seen), 32'h0);
        $display("[TB] packet abort by reset checked");

        pay_mem[0] = 8'h5A; pay_mem[1] = 8'h3C;
        send(2'd1, 2, 1'b0, 0, -1);
        exp_q = '{9'h109, 9'h15A, 9'h13C, 9'h06F};
        chk_log("after_reset", exp_q);

        repeat (3) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
